// File: rtl/condicionador_botoes.sv
// Button conditioning for the neurosync game core.
// Synchronizes the raw button bus, debounces presses and releases, and turns
// each accepted press into exactly one single-cycle event: "jogada" with a
// held one-hot code for a single button, or "jogada_invalida" for a chord.
// A new press is only considered after all buttons have been stably released.
module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                limpa,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_codigo,
    output logic                jogada_invalida,
    output logic                ocupado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_UM = CW'(1);
    localparam logic [N_BOTOES-1:0] BOT_ZERO = {N_BOTOES{1'b0}};

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRANDO    = 3'd1,
        EMITE        = 3'd2,
        ESPERA_SOLTA = 3'd3,
        SOLTANDO     = 3'd4
    } estado_t;

    // True when exactly one bit of the vector is set.
    function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
        logic [N_BOTOES-1:0] v_menos_um;
        v_menos_um = v - {{(N_BOTOES-1){1'b0}}, 1'b1};
        return (v != BOT_ZERO) && ((v & v_menos_um) == BOT_ZERO);
    endfunction

    logic [N_BOTOES-1:0] r_sinc_meta;
    logic [N_BOTOES-1:0] r_sinc;
    estado_t             r_estado;
    logic [CW-1:0]       r_cnt;
    logic [N_BOTOES-1:0] r_amostra;
    logic                r_jogada;
    logic                r_jogada_invalida;
    logic [N_BOTOES-1:0] r_jogada_codigo;
    logic                r_ocupado;

    estado_t             w_prox_estado;
    logic [CW-1:0]       w_prox_cnt;
    logic [N_BOTOES-1:0] w_prox_amostra;
    logic                w_emite;
    logic                w_valida;

    // Two-flop synchronizer bringing the asynchronous buttons into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc_meta <= BOT_ZERO;
            r_sinc      <= BOT_ZERO;
        end else if (limpa) begin
            r_sinc_meta <= BOT_ZERO;
            r_sinc      <= BOT_ZERO;
        end else begin
            r_sinc_meta <= botoes;
            r_sinc      <= r_sinc_meta;
        end
    end

    // Next-state, debounce counter and captured-sample logic of the press/release FSM.
    always_comb begin
        w_prox_estado  = r_estado;
        w_prox_cnt     = r_cnt;
        w_prox_amostra = r_amostra;
        case (r_estado)
            OCIOSO: begin
                if (r_sinc != BOT_ZERO) begin
                    w_prox_estado  = FILTRANDO;
                    w_prox_amostra = r_sinc;
                    w_prox_cnt     = CNT_ZERO;
                end else begin
                    w_prox_cnt = CNT_ZERO;
                end
            end
            FILTRANDO: begin
                if (r_sinc == r_amostra) begin
                    if (r_cnt == CNT_MAX) begin
                        w_prox_estado = EMITE;
                    end else begin
                        w_prox_cnt = r_cnt + CNT_UM;
                    end
                end else if (r_sinc == BOT_ZERO) begin
                    // Press shorter than the window: discard it.
                    w_prox_estado = OCIOSO;
                    w_prox_cnt    = CNT_ZERO;
                end else begin
                    // Bounce or chord change: restart the window on the new pattern.
                    w_prox_amostra = r_sinc;
                    w_prox_cnt     = CNT_ZERO;
                end
            end
            EMITE: begin
                w_prox_estado = ESPERA_SOLTA;
                w_prox_cnt    = CNT_ZERO;
            end
            ESPERA_SOLTA: begin
                if (r_sinc != BOT_ZERO) begin
                    w_prox_cnt = CNT_ZERO;
                end else begin
                    w_prox_estado = SOLTANDO;
                    w_prox_cnt    = CNT_ZERO;
                end
            end
            SOLTANDO: begin
                if (r_sinc != BOT_ZERO) begin
                    // Release bounce: go back to waiting, no new event.
                    w_prox_estado = ESPERA_SOLTA;
                    w_prox_cnt    = CNT_ZERO;
                end else if (r_cnt == CNT_MAX) begin
                    w_prox_estado = OCIOSO;
                    w_prox_cnt    = CNT_ZERO;
                end else begin
                    w_prox_cnt = r_cnt + CNT_UM;
                end
            end
            default: begin
                w_prox_estado  = OCIOSO;
                w_prox_cnt     = CNT_ZERO;
                w_prox_amostra = BOT_ZERO;
            end
        endcase
    end

    // The event pulse is registered on the same edge that enters EMITE.
    assign w_emite  = (r_estado == FILTRANDO) && (w_prox_estado == EMITE);
    assign w_valida = eh_one_hot(r_amostra);

    // FSM state, counter, sample and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado          <= OCIOSO;
            r_cnt             <= CNT_ZERO;
            r_amostra         <= BOT_ZERO;
            r_jogada          <= 1'b0;
            r_jogada_invalida <= 1'b0;
            r_jogada_codigo   <= BOT_ZERO;
            r_ocupado         <= 1'b0;
        end else if (limpa) begin
            r_estado          <= OCIOSO;
            r_cnt             <= CNT_ZERO;
            r_amostra         <= BOT_ZERO;
            r_jogada          <= 1'b0;
            r_jogada_invalida <= 1'b0;
            r_jogada_codigo   <= BOT_ZERO;
            r_ocupado         <= 1'b0;
        end else begin
            r_estado          <= w_prox_estado;
            r_cnt             <= w_prox_cnt;
            r_amostra         <= w_prox_amostra;
            r_jogada          <= w_emite && w_valida;
            r_jogada_invalida <= w_emite && !w_valida;
            r_ocupado         <= (w_prox_estado != OCIOSO);
            if (w_emite && w_valida) begin
                r_jogada_codigo <= r_amostra;
            end else begin
                r_jogada_codigo <= r_jogada_codigo;
            end
        end
    end

    assign jogada          = r_jogada;
    assign jogada_invalida = r_jogada_invalida;
    assign jogada_codigo   = r_jogada_codigo;
    assign ocupado         = r_ocupado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes: press, short press, bounce, chord,
// long hold with release bounce, asynchronous reset and synchronous clear.
module tb_condicionador_botoes;

    logic       clock;
    logic       reset;
    logic       limpa;
    logic [3:0] botoes;
    logic       jogada;
    logic [3:0] jogada_codigo;
    logic       jogada_invalida;
    logic       ocupado;

    int checks;
    int errors;
    int edge_idx;
    int n_jog;
    int n_inv;
    int jog_edge;
    int n_both;
    int n_consec;
    logic prev_pulse;

    condicionador_botoes #(
        .N_BOTOES(4),
        .DEBOUNCE_CICLOS(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .limpa(limpa),
        .botoes(botoes),
        .jogada(jogada),
        .jogada_codigo(jogada_codigo),
        .jogada_invalida(jogada_invalida),
        .ocupado(ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_counts();
        edge_idx = 0;
        n_jog    = 0;
        n_inv    = 0;
        jog_edge = 0;
        n_both   = 0;
        n_consec = 0;
    endtask

    // Advance one rising edge and log the pulses seen after it.
    task automatic tick();
        @(posedge clock);
        #1;
        edge_idx++;
        if (jogada) begin
            n_jog++;
            if (jog_edge == 0) jog_edge = edge_idx;
        end
        if (jogada_invalida) n_inv++;
        if (jogada && jogada_invalida) n_both++;
        if ((jogada || jogada_invalida) && prev_pulse) n_consec++;
        prev_pulse = jogada || jogada_invalida;
    endtask

    // Drive a button pattern just before an edge and hold it for n edges.
    task automatic apply(input logic [3:0] v, input int n);
        clear_counts();
        @(negedge clock);
        botoes = v;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; limpa = 1'b0; botoes = 4'b0000; prev_pulse = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({jogada, jogada_invalida, ocupado, jogada_codigo} !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000", {jogada, jogada_invalida, ocupado, jogada_codigo});
        end
        @(negedge clock);
        reset = 1'b1;
        apply(4'b0000, 3);
        checks++;
        if (ocupado !== 1'b0 || n_jog != 0) begin
            errors++;
            $display("FAIL reset_idle: ocupado=%b jog=%0d expected 0 0", ocupado, n_jog);
        end
    endtask

    task automatic test_clean_press();
        apply(4'b0001, 10);
        checks++;
        if (n_jog != 1 || jog_edge != 8) begin
            errors++;
            $display("FAIL clean_pulse: count=%0d edge=%0d expected 1 at 8", n_jog, jog_edge);
        end
        checks++;
        if (n_inv != 0) begin
            errors++;
            $display("FAIL clean_no_invalid: got %0d expected 0", n_inv);
        end
        checks++;
        if (jogada_codigo !== 4'b0001 || ocupado !== 1'b1) begin
            errors++;
            $display("FAIL clean_code: codigo=%b ocupado=%b expected 0001 1", jogada_codigo, ocupado);
        end
        apply(4'b0000, 7);
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL release_edge7: ocupado=%b expected 1", ocupado);
        end
        tick();
        checks++;
        if (ocupado !== 1'b0 || jogada_codigo !== 4'b0001 || n_jog != 0) begin
            errors++;
            $display("FAIL release_edge8: ocupado=%b codigo=%b jog=%0d expected 0 0001 0", ocupado, jogada_codigo, n_jog);
        end
    endtask

    task automatic test_short_press();
        apply(4'b1000, 3);
        apply(4'b0000, 10);
        checks++;
        if (n_jog != 0 || n_inv != 0 || ocupado !== 1'b0 || jogada_codigo !== 4'b0001) begin
            errors++;
            $display("FAIL short_press: jog=%0d inv=%0d ocupado=%b codigo=%b expected 0 0 0 0001",
                     n_jog, n_inv, ocupado, jogada_codigo);
        end
    endtask

    task automatic test_bounce();
        int total;
        apply(4'b0100, 2);
        total = n_jog;
        apply(4'b0000, 1);
        total += n_jog;
        apply(4'b0100, 10);
        total += n_jog;
        checks++;
        if (total != 1 || n_inv != 0 || jogada_codigo !== 4'b0100) begin
            errors++;
            $display("FAIL bounce: jog=%0d inv=%0d codigo=%b expected 1 0 0100", total, n_inv, jogada_codigo);
        end
        apply(4'b0000, 10);
        checks++;
        if (ocupado !== 1'b0 || n_jog != 0) begin
            errors++;
            $display("FAIL bounce_release: ocupado=%b jog=%0d expected 0 0", ocupado, n_jog);
        end
    endtask

    task automatic test_chord();
        apply(4'b0101, 10);
        checks++;
        if (n_inv != 1 || n_jog != 0) begin
            errors++;
            $display("FAIL chord_pulse: inv=%0d jog=%0d expected 1 0", n_inv, n_jog);
        end
        checks++;
        if (jogada_codigo !== 4'b0100 || n_both != 0) begin
            errors++;
            $display("FAIL chord_code: codigo=%b both=%0d expected 0100 0", jogada_codigo, n_both);
        end
        apply(4'b0000, 10);
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL chord_release: ocupado=%b expected 0", ocupado);
        end
    endtask

    task automatic test_long_hold();
        int total;
        apply(4'b0010, 50);
        checks++;
        if (n_jog != 1 || n_consec != 0 || jogada_codigo !== 4'b0010) begin
            errors++;
            $display("FAIL long_hold: jog=%0d consec=%0d codigo=%b expected 1 0 0010", n_jog, n_consec, jogada_codigo);
        end
        apply(4'b0000, 2);
        total = n_jog + n_inv;
        apply(4'b0010, 1);
        total += n_jog + n_inv;
        apply(4'b0000, 10);
        total += n_jog + n_inv;
        checks++;
        if (total != 0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL release_bounce: events=%0d ocupado=%b expected 0 0", total, ocupado);
        end
        apply(4'b0001, 10);
        checks++;
        if (n_jog != 1 || jog_edge != 8 || jogada_codigo !== 4'b0001) begin
            errors++;
            $display("FAIL new_press: jog=%0d edge=%0d codigo=%b expected 1 8 0001", n_jog, jog_edge, jogada_codigo);
        end
        apply(4'b0000, 10);
    endtask

    task automatic test_reset_mid();
        apply(4'b0100, 4);
        @(negedge clock);
        reset = 1'b0;
        botoes = 4'b0000;
        #1;
        checks++;
        if ({jogada, jogada_invalida, ocupado, jogada_codigo} !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_async: got %b expected 0000000", {jogada, jogada_invalida, ocupado, jogada_codigo});
        end
        @(negedge clock);
        reset = 1'b1;
        apply(4'b0000, 10);
        checks++;
        if (n_jog != 0 || n_inv != 0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: jog=%0d inv=%0d ocupado=%b expected 0 0 0", n_jog, n_inv, ocupado);
        end
    endtask

    task automatic test_limpa();
        apply(4'b1000, 10);
        checks++;
        if (n_jog != 1 || jogada_codigo !== 4'b1000) begin
            errors++;
            $display("FAIL limpa_setup: jog=%0d codigo=%b expected 1 1000", n_jog, jogada_codigo);
        end
        @(negedge clock);
        limpa = 1'b1;
        clear_counts();
        tick();
        limpa = 1'b0;
        checks++;
        if (jogada_codigo !== 4'b0000 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL limpa_clear: codigo=%b ocupado=%b expected 0000 0", jogada_codigo, ocupado);
        end
        clear_counts();
        repeat (12) tick();
        checks++;
        if (n_jog != 1 || jog_edge != 8 || jogada_codigo !== 4'b1000) begin
            errors++;
            $display("FAIL limpa_held: jog=%0d edge=%0d codigo=%b expected 1 8 1000", n_jog, jog_edge, jogada_codigo);
        end
        apply(4'b0000, 10);
        checks++;
        if (ocupado !== 1'b0 || n_jog != 0) begin
            errors++;
            $display("FAIL limpa_release: ocupado=%b jog=%0d expected 0 0", ocupado, n_jog);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_counts();
        test_reset();
        test_clean_press();
        test_short_press();
        test_bounce();
        test_chord();
        test_long_hold();
        test_reset_mid();
        test_limpa();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
